// File: rtl/gf_alu_pipe.sv
// Multi-lane GF(2^m) multiply/divide/inverse/square unit, three-stage log/antilog pipeline
// with a single global advance enable and a saturating count of error beats.
module gf_alu_pipe #(
    parameter int          SYMB_WIDTH = 8,
    parameter int unsigned PRIM_POLY  = 'h11D,
    parameter int          LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_op,
    input  logic [LANES*SYMB_WIDTH-1:0] in_a,
    input  logic [LANES*SYMB_WIDTH-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*SYMB_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_err,
    input  logic                        err_clr,
    output logic [15:0]                 err_cnt
);
    localparam int         M    = SYMB_WIDTH;
    localparam int         TBL  = 1 << M;
    localparam logic [M:0] NMOD = (M+1)'(TBL - 1);

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;

    function automatic logic [TBL*M-1:0] build_alog();
        logic [TBL*M-1:0] t;
        logic [M:0]       v;
        t = '0;
        v = (M+1)'(1);
        for (int i = 0; i < TBL - 1; i++) begin
            t[i*M +: M] = v[M-1:0];
            v = v << 1;
            if (v[M]) v = v ^ (M+1)'(PRIM_POLY);
        end
        return t;
    endfunction

    function automatic logic [TBL*M-1:0] build_log();
        logic [TBL*M-1:0] t;
        logic [M:0]       v;
        t = '0;
        v = (M+1)'(1);
        for (int i = 0; i < TBL - 1; i++) begin
            t[int'(v[M-1:0])*M +: M] = M'(i);
            v = v << 1;
            if (v[M]) v = v ^ (M+1)'(PRIM_POLY);
        end
        return t;
    endfunction

    localparam logic [TBL*M-1:0] ALOG = build_alog();
    localparam logic [TBL*M-1:0] LOG  = build_log();

    function automatic logic [M-1:0] log_of(input logic [M-1:0] x);
        return LOG[int'(x)*M +: M];
    endfunction

    function automatic logic [M-1:0] alog_of(input logic [M-1:0] x);
        return ALOG[int'(x)*M +: M];
    endfunction

    // Operands are always below 2N, so one conditional subtract reduces mod N.
    function automatic logic [M-1:0] mod_n(input logic [M:0] s);
        logic [M:0] r;
        r = (s >= NMOD) ? s - NMOD : s;
        return r[M-1:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic                    vld_p0, vld_p1;
    logic [1:0]              op_p0;
    logic [LANES-1:0][M-1:0] la_p0, lb_p0, e_p1, e_c;
    logic [LANES-1:0]        za_p0, zb_p0, zr_p1, er_p1, zr_c, er_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
        end
    end

    // Stage 1: operand logarithms and zero flags.
    always_ff @(posedge clk) begin
        if (en) begin
            op_p0 <= in_op;
            for (int i = 0; i < LANES; i++) begin
                la_p0[i] <= log_of(in_a[i*M +: M]);
                lb_p0[i] <= log_of(in_b[i*M +: M]);
                za_p0[i] <= (in_a[i*M +: M] == '0);
                zb_p0[i] <= (in_b[i*M +: M] == '0);
            end
        end
    end

    always_comb begin
        e_c  = '0;
        zr_c = '0;
        er_c = '0;
        for (int i = 0; i < LANES; i++) begin
            case (op_p0)
                OP_MUL: begin
                    e_c[i]  = mod_n({1'b0, la_p0[i]} + {1'b0, lb_p0[i]});
                    zr_c[i] = za_p0[i] | zb_p0[i];
                end
                OP_DIV: begin
                    e_c[i]  = mod_n({1'b0, la_p0[i]} + NMOD - {1'b0, lb_p0[i]});
                    zr_c[i] = za_p0[i] | zb_p0[i];
                    er_c[i] = zb_p0[i];
                end
                OP_INV: begin
                    e_c[i]  = mod_n(NMOD - {1'b0, la_p0[i]});
                    zr_c[i] = za_p0[i];
                    er_c[i] = za_p0[i];
                end
                default: begin
                    e_c[i]  = mod_n({la_p0[i], 1'b0});
                    zr_c[i] = za_p0[i];
                end
            endcase
        end
    end

    // Stage 2: result exponent and zero/error flags.
    always_ff @(posedge clk) begin
        if (en) begin
            e_p1  <= e_c;
            zr_p1 <= zr_c;
            er_p1 <= er_c;
        end
    end

    // Stage 3: antilog onto the output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data <= '0;
            out_err  <= '0;
        end else if (en) begin
            for (int i = 0; i < LANES; i++) begin
                out_data[i*M +: M] <= zr_p1[i] ? '0 : alog_of(e_p1[i]);
                out_err[i]         <= er_p1[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && (|out_err)) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
endmodule

// File: tb/tb_gf_alu_pipe.sv
// Bench for gf_alu_pipe: directed and random beats checked against a polynomial-arithmetic
// GF(2^8) model with a stage-count timing model of the valid/ready pipeline.
module tb_gf_alu_pipe;
    localparam int M = 8;
    localparam int L = 4;
    localparam int W = M * L;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic [L-1:0] out_err;
    logic         err_clr = 1'b0;
    logic [15:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf_alu_pipe #(.SYMB_WIDTH(M), .PRIM_POLY('h11D), .LANES(L)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [L-1:0] err;
        int           stage;
    } beat_t;

    beat_t       q[$];
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++) if (gf_mul(a, 8'(y)) == 8'h01) r = 8'(y);
        return r;
    endfunction

    task automatic model_beat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] d, output logic [L-1:0] e);
        logic [7:0] x, y, r;
        logic       f;
        d = '0;
        e = '0;
        for (int i = 0; i < L; i++) begin
            x = a[i*M +: M];
            y = b[i*M +: M];
            r = 8'h00;
            f = 1'b0;
            case (op)
                2'd0: r = gf_mul(x, y);
                2'd1: if (y == 8'h00) f = 1'b1; else r = gf_mul(x, gf_inv(y));
                2'd2: if (x == 8'h00) f = 1'b1; else r = gf_inv(x);
                default: r = gf_mul(x, x);
            endcase
            d[i*M +: M] = r;
            e[i] = f;
        end
    endtask

    function automatic logic [7:0] rsym();
        return ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    endfunction

    function automatic logic [W-1:0] rvec();
        return {rsym(), rsym(), rsym(), rsym()};
    endfunction

    // One clock cycle: entered and left at the falling edge with inputs already driven.
    task automatic tick(output bit acc, output bit cons);
        bit    ov_e, en_e, cons_err;
        beat_t nb;
        #1;
        ov_e = (q.size() > 0) && (q[0].stage == 3);
        en_e = !ov_e || out_ready;
        chk("in_ready", {63'd0, in_ready}, {63'd0, en_e});
        acc = in_valid && en_e;
        cons = ov_e && out_ready;
        cons_err = 1'b0;
        if (cons) cons_err = |q[0].err;
        nb.data = '0;
        nb.err = '0;
        nb.stage = 1;
        if (acc) model_beat(in_op, in_a, in_b, nb.data, nb.err);
        @(posedge clk);
        if (en_e) begin
            foreach (q[i]) q[i].stage++;
            if (q.size() > 0 && q[0].stage > 3) void'(q.pop_front());
        end
        if (acc) q.push_back(nb);
        if (err_clr) exp_cnt = '0;
        else if (cons_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        #1;
        ov_e = (q.size() > 0) && (q[0].stage == 3);
        chk("out_valid", {63'd0, out_valid}, {63'd0, ov_e});
        if (ov_e) begin
            chk("out_data", 64'(out_data), 64'(q[0].data));
            chk("out_err", 64'(out_err), 64'(q[0].err));
        end
        chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
        @(negedge clk);
    endtask

    task automatic run_single(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output int lat);
        bit acc, cons;
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick(acc, cons);
        chk("single_accept", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick(acc, cons);
            lat++;
        end
    endtask

    task automatic stream_errors(input int nbeats);
        bit acc, cons;
        int sent, done, guard;
        sent = 0;
        done = 0;
        guard = 0;
        in_op = 2'd2;
        in_a = '0;
        out_ready = 1'b1;
        while (done < nbeats && guard < nbeats + 20) begin
            in_valid = (sent < nbeats);
            tick(acc, cons);
            if (acc) sent++;
            if (cons) done++;
            guard++;
        end
        in_valid = 1'b0;
        chk("err_stream_done", 64'(done), 64'(nbeats));
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bit          acc, cons;
        int          lat, sent, done;
        logic [15:0] c0;

        #1 rstn = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_single(2'd0, {rsym(), rsym(), rsym(), 8'h02}, {rsym(), rsym(), rsym(), 8'h80}, lat);
        chk("mul_latency", 64'(lat), 64'd3);
        chk("mul_02_80", 64'(out_data[7:0]), 64'h1D);
        chk("mul_02_80_err", {63'd0, out_err[0]}, 64'd0);
        tick(acc, cons);

        run_single(2'd1, {rsym(), rsym(), rsym(), 8'h1D}, {8'h01, 8'h02, 8'h03, 8'h02}, lat);
        chk("div_1d_02", 64'(out_data[7:0]), 64'h80);
        chk("div_err", 64'(out_err), 64'd0);
        tick(acc, cons);
        run_single(2'd2, {8'h05, 8'h06, 8'h02, 8'h07}, rvec(), lat);
        chk("inv_02", 64'(out_data[15:8]), 64'h8E);
        chk("inv_err", 64'(out_err), 64'd0);
        tick(acc, cons);
        run_single(2'd3, {rsym(), 8'h80, rsym(), rsym()}, rvec(), lat);
        chk("sqr_80", 64'(out_data[23:16]), 64'h13);
        tick(acc, cons);
        run_single(2'd0, {8'h00, rsym(), rsym(), rsym()}, {8'h55, rsym(), rsym(), rsym()}, lat);
        chk("mul_zero", 64'(out_data[31:24]), 64'h00);
        chk("mul_zero_err", {63'd0, out_err[3]}, 64'd0);
        tick(acc, cons);

        run_single(2'd1, {8'h11, 8'h22, 8'h33, 8'h37}, {8'h04, 8'h05, 8'h06, 8'h00}, lat);
        chk("div0_err", 64'(out_err), 64'b0001);
        chk("div0_data", 64'(out_data[7:0]), 64'h00);
        c0 = err_cnt;
        tick(acc, cons);
        chk("div0_cnt", 64'(err_cnt), 64'(c0 + 16'd1));
        run_single(2'd2, {8'h09, 8'h00, 8'h07, 8'h03}, rvec(), lat);
        chk("inv0_err", 64'(out_err), 64'b0100);
        chk("inv0_data", 64'(out_data[23:16]), 64'h00);
        c0 = err_cnt;
        tick(acc, cons);
        chk("inv0_cnt", 64'(err_cnt), 64'(c0 + 16'd1));

        sent = 0;
        done = 0;
        for (int i = 0; i < 25; i++) begin
            in_valid = (sent < 10);
            in_op = 2'($urandom_range(0, 3));
            in_a = rvec();
            in_b = rvec();
            out_ready = !(i >= 5 && i <= 7);
            tick(acc, cons);
            if (acc) sent++;
            if (cons) done++;
        end
        chk("stream_sent", 64'(sent), 64'd10);
        chk("stream_delivered", 64'(done), 64'd10);
        in_valid = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 2'($urandom_range(0, 3));
            in_a = rvec();
            in_b = rvec();
            out_ready = ($urandom_range(0, 9) < 7);
            err_clr = ($urandom_range(0, 19) == 0);
            tick(acc, cons);
        end
        err_clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick(acc, cons);

        stream_errors(2);
        in_valid = 1'b1;
        in_op = 2'd0;
        for (int i = 0; i < 3; i++) begin
            in_a = rvec();
            in_b = rvec();
            tick(acc, cons);
        end
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("flight_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("flight_rst_cnt", 64'(err_cnt), 64'd0);
        chk("flight_rst_ready", {63'd0, in_ready}, 64'd1);
        q.delete();
        exp_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) tick(acc, cons);

        err_clr = 1'b1;
        tick(acc, cons);
        err_clr = 1'b0;
        stream_errors(65534);
        chk("sat_fffe", 64'(err_cnt), 64'hFFFE);
        stream_errors(3);
        chk("sat_ffff", 64'(err_cnt), 64'hFFFF);

        in_op = 2'd1;
        in_a = rvec();
        in_b = '0;
        in_valid = 1'b1;
        tick(acc, cons);
        in_valid = 1'b0;
        tick(acc, cons);
        tick(acc, cons);
        chk("clr_beat_valid", {63'd0, out_valid}, 64'd1);
        err_clr = 1'b1;
        tick(acc, cons);
        err_clr = 1'b0;
        chk("clr_priority", 64'(err_cnt), 64'd0);
        tick(acc, cons);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gf_alu_pipe.md
GF_ALU_PIPE -- requirements
Module: gf_alu_pipe

Interface
REQ-001 Parameter SYMB_WIDTH, default 8, symbol width m of GF(2^m); legal range 3..10.
REQ-002 Parameter PRIM_POLY, default 'h11D, primitive polynomial of degree SYMB_WIDTH including the x^m term; log/antilog tables are built from it at elaboration.
REQ-003 Parameter LANES, default 4, number of independent symbol lanes per beat.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rstn  input  1  reset; asynchronous, active-low.
REQ-006 Port in_valid  input  1  input beat present.
REQ-007 Port in_ready  output  1  block accepts the input beat this cycle.
REQ-008 Port in_op  input  2  opcode for all lanes: 0 MUL (A*B), 1 DIV (A/B), 2 INV (1/A, B ignored), 3 SQR (A*A, B ignored).
REQ-009 Port in_a  input  LANES*SYMB_WIDTH  operand A; lane i is bits [i*m +: m].
REQ-010 Port in_b  input  LANES*SYMB_WIDTH  operand B, same lane packing.
REQ-011 Port out_valid  output  1  result beat present.
REQ-012 Port out_ready  input  1  downstream accepts the result beat.
REQ-013 Port out_data  output  LANES*SYMB_WIDTH  results, same lane packing.
REQ-014 Port out_err  output  LANES  per-lane divide-by-zero / inverse-of-zero flag.
REQ-015 Port err_clr  input  1  synchronous clear of err_cnt.
REQ-016 Port err_cnt  output  16  saturating count of output beats with any out_err bit set.

Function
REQ-017 Three register stages: S1 registers log(A), log(B), zero flags and op per lane; S2 registers exponent e and result-zero/err flags; S3 registers antilog(e) or 0, plus err, onto out_data/out_err.
REQ-018 Each stage carries a valid bit; latency from an accepted input to out_valid is exactly 3 cycles with no stall.
REQ-019 Advance enable en = !out_valid || out_ready; in_ready = en; when en=1 all stages shift (bubbles included); when en=0 all stage registers hold.
REQ-020 An input beat is accepted only when in_valid && in_ready; a result beat is consumed only when out_valid && out_ready.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_err and out_valid remain stable.
REQ-022 Full throughput: with out_ready held 1, one beat is accepted and one result is produced per cycle.
REQ-023 Log domain: log(x) in 0..2^m-2 for x != 0; N = 2^m-1; exponent arithmetic uses m+1 bits and never overflows.
REQ-024 MUL: e = (la+lb) mod N; result 0 if A=0 or B=0; err=0.
REQ-025 DIV: e = la-lb, plus N if negative; result 0 if A=0; if B=0 result 0 and err=1.
REQ-026 INV: e = (N-la) mod N; if A=0 result 0 and err=1.
REQ-027 SQR: e = (2*la) mod N; result 0 if A=0; err=0.
REQ-028 Lanes are fully independent; one lane's zero/err condition does not affect other lanes.
REQ-029 err_cnt increments by 1 on each consumed result beat with |out_err=1, saturating at 16'hFFFF.
REQ-030 err_clr=1 sets err_cnt to 0 on the next edge and takes priority over a simultaneous increment.

Reset
REQ-031 On rstn low, asynchronously: all stage valid bits, out_valid, out_data, out_err and err_cnt go to 0.
REQ-032 in_ready is 1 during and after reset (en=1 since out_valid=0); beats in flight at reset are discarded, not emitted.
REQ-033 Release of rstn is synchronised externally; the first edge after release can accept a beat.

Verification
REQ-034 m=8, 0x11D, lane0 MUL A=0x02 B=0x80 -> out_data lane0 = 0x1D, err=0, out_valid exactly 3 cycles after acceptance.
REQ-035 Lane0 DIV A=0x1D B=0x02 -> 0x80; lane1 INV A=0x02 -> 0x8E; lane2 SQR A=0x80 -> 0x13; lane3 MUL A=0x00 B=0x55 -> 0x00; all err=0.
REQ-036 DIV lane0 B=0x00 A=0x37 and INV lane2 A=0x00 -> those lanes result 0, err=1, other lanes err=0; err_cnt increments by 1 on consumption.
REQ-037 Stream 10 back-to-back beats, out_ready low on cycles 5-7 -> in_ready low on the same cycles, outputs held stable, all 10 results delivered in order with none lost or duplicated.
REQ-038 Assert rstn low with 3 beats in flight -> out_valid=0, err_cnt=0 immediately; after release no stale result appears.
REQ-039 Preload err_cnt=16'hFFFE, deliver 3 error beats -> saturates at 16'hFFFF; err_clr with simultaneous error beat -> err_cnt=0.
